// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Brief    : Bus-programmable bank of PWM channels with shared prescaler,
//            period counter and shadow-buffered period/duty registers.
// Revision : 1.0
// ============================================================================
module pwm_bank #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                wren,
    input  logic [3:0]          adr,
    input  logic [31:0]         di,
    output logic [31:0]         dout,
    output logic [CHANNELS-1:0] out,
    output logic                wrap
);

    localparam logic [3:0] c_ADR_CTRL     = 4'd0;
    localparam logic [3:0] c_ADR_PERIOD   = 4'd1;
    localparam logic [3:0] c_ADR_PRESCALE = 4'd2;
    localparam logic [3:0] c_ADR_STATUS   = 4'd3;

    logic [CHANNELS-1:0]   r_en;
    logic [CHANNELS-1:0]   r_pol;
    logic                  r_run;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_psc;
    logic                  r_status;
    logic [WIDTH-1:0]      r_period_sh;
    logic [WIDTH-1:0]      r_period_act;
    logic [WIDTH-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_duty_sh  [CHANNELS];
    logic [WIDTH-1:0]      r_duty_act [CHANNELS];
    logic [CHANNELS-1:0]   r_out;
    logic                  r_wrap;
    logic [31:0]           r_dout;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tick;
    logic                  w_wrap_ev;
    logic                  w_load;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_wr      = cs & wren;
    assign w_rd      = cs & ~wren;
    assign w_tick    = r_run && (r_psc >= r_prescale);
    assign w_wrap_ev = w_tick && (r_cnt >= r_period_act);
    // Active values follow the shadows freely while stopped, else only at wrap.
    assign w_load    = !r_run || w_wrap_ev;
    assign w_unused  = ^di;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en       <= '0;
            r_pol      <= '0;
            r_run      <= 1'b0;
            r_prescale <= '0;
        end else if (w_wr && adr == c_ADR_CTRL) begin
            r_en  <= di[CHANNELS-1:0];
            r_pol <= di[8 +: CHANNELS];
            r_run <= di[31];
        end else if (w_wr && adr == c_ADR_PRESCALE) begin
            r_prescale <= di[PRESCALE_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_sh  <= '1;
            r_period_act <= '1;
        end else begin
            if (w_load)
                r_period_act <= r_period_sh;
            if (w_wr && adr == c_ADR_PERIOD)
                r_period_sh <= di[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psc  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_ev;
            if (!r_run) begin
                r_psc <= '0;
                r_cnt <= '0;
            end else if (w_tick) begin
                r_psc <= '0;
                r_cnt <= w_wrap_ev ? '0 : r_cnt + 1'b1;
            end else begin
                r_psc <= r_psc + 1'b1;
            end
        end
    end

    // A wrap in the same cycle as a write-1-clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_status <= 1'b0;
        else if (w_wrap_ev)
            r_status <= 1'b1;
        else if (w_wr && adr == c_ADR_STATUS && di[0])
            r_status <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i]  <= '0;
                r_duty_act[i] <= '0;
            end
            r_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load)
                    r_duty_act[i] <= r_duty_sh[i];
                if (w_wr && adr == 4'(8 + i))
                    r_duty_sh[i] <= di[WIDTH-1:0];
                // Extra MSB keeps duty > period fully on and duty = 0 fully off.
                r_out[i] <= (r_en[i] & r_run &
                             ({1'b0, r_cnt} < {1'b0, r_duty_act[i]})) ^ r_pol[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (adr)
            c_ADR_CTRL: begin
                w_rdata[CHANNELS-1:0]  = r_en;
                w_rdata[8 +: CHANNELS] = r_pol;
                w_rdata[31]            = r_run;
            end
            c_ADR_PERIOD:   w_rdata[WIDTH-1:0]      = r_period_sh;
            c_ADR_PRESCALE: w_rdata[PRESCALE_W-1:0] = r_prescale;
            c_ADR_STATUS:   w_rdata[0]              = r_status;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (adr == 4'(8 + i))
                        w_rdata[WIDTH-1:0] = r_duty_sh[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dout <= '0;
        else
            r_dout <= w_rd ? w_rdata : 32'd0;
    end

    assign dout = r_dout;
    assign out  = r_out;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of PWM channels, legal range 1..8.
REQ-002 SHALL have parameter WIDTH, default 8, counter/period/duty width in bits, legal range 4..16.
REQ-003 SHALL have parameter PRESCALE_W, default 8, prescaler register width in bits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port cs, input, 1 bit, chip select for one bus access per cycle.
REQ-007 SHALL have port wren, input, 1 bit, write when cs=1, read otherwise.
REQ-008 SHALL have port adr, input, 4 bits, word register index.
REQ-009 SHALL have port di, input, 32 bits, write data.
REQ-010 SHALL have port do, output, 32 bits, read data; zero when not returning a read (OR-bus).
REQ-011 SHALL have port out, output, CHANNELS bits, PWM waveforms.
REQ-012 SHALL have port wrap, output, 1 bit, one-cycle pulse at each period wrap.

Function
REQ-013 SHALL decode the register map: 0 CTRL, 1 PERIOD, 2 PRESCALE, 3 STATUS, 8+n DUTY[n]; other indexes read 0 and ignore writes.
REQ-014 SHALL use CTRL as follows: [7:0] per-channel enable, [15:8] per-channel polarity invert, [31] global run; bits beyond CHANNELS read 0.
REQ-015 SHALL return read data one cycle after cs=1,wren=0, zero-extended, and SHALL drive do=0 in all other cycles.
REQ-016 SHALL apply a write in the cycle cs=1,wren=1, taking the low WIDTH or PRESCALE_W bits of di.
REQ-017 SHALL run the prescaler only while run=1: count 0..PRESCALE, then emit a tick and return to 0; PRESCALE=0 gives a tick every cycle.
REQ-018 SHALL advance the counter on each tick: 0..PERIOD_act, then wrap to 0.
REQ-019 SHALL register the wrap pulse in the cycle the counter moves PERIOD_act->0.
REQ-020 SHALL hold PERIOD and DUTY[n] writes in shadow registers.
REQ-021 SHALL copy shadows to the active registers on wrap, or every cycle while run=0.
REQ-022 SHALL read back PERIOD and DUTY as the shadow values.
REQ-023 SHALL, when a shadow write coincides with a wrap, load active from the pre-write shadow; the new value applies at the next wrap.
REQ-024 SHALL register out[n] = (en[n] & run & (cnt < DUTY_act[n])) XOR pol[n]; disabled or stopped channels output pol[n].
REQ-025 SHALL compare in WIDTH+1 bits so that DUTY_act > PERIOD_act gives constant active, and DUTY=0 gives constant inactive.
REQ-026 SHALL, when PERIOD_act=0, keep cnt at 0 and pulse wrap on every tick.
REQ-027 SHALL set STATUS[0] (sticky) on wrap and clear it on a write with di[0]=1; set wins when both occur in the same cycle.
REQ-028 SHALL, on clearing run, reset the prescaler and cnt to 0 in the next cycle; on setting run, start counting from 0.

Reset
REQ-029 SHALL, on reset, asynchronously clear CTRL, PRESCALE, STATUS, DUTY shadow/active, cnt, prescaler, out, wrap and do to 0.
REQ-030 SHALL, on reset, set PERIOD shadow/active to 2^WIDTH-1.
REQ-031 SHALL, on reset mid-period, take no pending shadow into effect; after release the block behaves as freshly reset.

Verification
REQ-032 SHALL verify reset: assert reset mid-run -> out=0, do=0, PERIOD reads 0xFF (WIDTH=8), STATUS reads 0.
REQ-033 SHALL verify basic PWM: PERIOD=9, PRESCALE=0, DUTY0=3, CTRL=0x8000_0001 -> out[0] high 3 of every 10 cycles, wrap every 10 cycles.
REQ-034 SHALL verify shadowing: while running with DUTY0=3, write DUTY0=7 mid-period -> high time stays 3 until the wrap, then 7; repeat the write in the wrap cycle -> the change is deferred one extra period.
REQ-035 SHALL verify boundaries: DUTY0=0 -> constant 0; DUTY0=10 with PERIOD=9 -> constant 1; pol bit 8 set -> inverted; PERIOD=0 -> wrap every tick.
REQ-036 SHALL verify the prescaler: PRESCALE=3, PERIOD=4 -> wrap every 20 cycles; clearing run -> out=pol, cnt back to 0, restart phase-aligned.
REQ-037 SHALL verify the bus: a read of index 5 returns 0; do is 0 in non-read cycles; a STATUS write-1-clear coinciding with a wrap leaves STATUS[0]=1.
